// File: rtl/bus_mux_sequencer.sv
// bus_mux_sequencer: splits CPU accesses outside the 16-bit region into odd/even byte cycles on the 8-bit bus
// Optional build macro MUX_TURBO_EN: each byte phase lasts a single clk_en tick regardless of WAIT_CYCLES.
// Word address a_i[14] corresponds to CPU address line A0 (MSB); data bit [15] is CPU bit 0 (MSB), so the
// odd byte (CPU bits 8..15) is data[7:0].
module bus_mux_sequencer #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic        memen_i,
  input  logic        dbin_i,
  input  logic        we_i,
  input  logic [14:0] a_i,
  input  logic [15:0] cpu_data_out_i,
  input  logic [7:0]  ext_data_in_i,
  output logic        ready_o,
  output logic        a15_o,
  output logic [7:0]  ext_data_out_o,
  output logic        ext_we_o,
  output logic [15:0] cpu_data_in_o,
  output logic        busy_o
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
`ifdef MUX_TURBO_EN
  localparam logic [CW-1:0] LOAD = '0;
`else
  localparam logic [CW-1:0] LOAD = CW'(WAIT_CYCLES - 1);
`endif
  typedef enum logic [1:0] {IDLE, ODD, EVEN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, a15_q, a15_d;
  logic [15:0] rdata_q, rdata_d;
  logic wide, unused_a;
  assign wide = (a_i[14:12] == 3'b000) || (a_i[14:12] == 3'b100 && a_i[11:9] == 3'b000);
  assign unused_a = ^a_i[8:0];
  // state, counter and registered CPU-facing outputs; everything holds while clk_en is low
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      a15_q   <= 1'b0;
      rdata_q <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      a15_q   <= a15_d;
      rdata_q <= rdata_d;
    end
  end
  // sequencing: start on a narrow access, count each byte phase, abort whenever memen drops mid-sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    a15_d   = a15_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (memen_i && !wide) begin
        state_d = ODD;
        ready_d = 1'b0;
        a15_d   = 1'b1;
        cnt_d   = LOAD;
      end
      ODD: if (!memen_i) begin
        state_d = IDLE;
        ready_d = 1'b1;
        a15_d   = 1'b0;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        rdata_d[7:0] = dbin_i ? ext_data_in_i : rdata_q[7:0];
        state_d      = EVEN;
        a15_d        = 1'b0;
        cnt_d        = LOAD;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      EVEN: if (!memen_i) begin
        state_d = IDLE;
        ready_d = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q == '0) begin
        rdata_d[15:8] = dbin_i ? ext_data_in_i : rdata_q[15:8];
        state_d       = DONE;
        ready_d       = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      DONE: state_d = memen_i ? DONE : IDLE;
    endcase
  end
  // 8-bit bus side: write strobe and byte lane only while a byte phase of a live write is running
  always_comb begin
    busy_o         = (state_q == ODD) || (state_q == EVEN);
    ext_we_o       = ((state_q == ODD) || (state_q == EVEN)) && memen_i && we_i && !dbin_i;
    ext_data_out_o = (state_q == ODD) ? cpu_data_out_i[7:0] : (state_q == EVEN) ? cpu_data_out_i[15:8] : 8'h00;
  end
  assign ready_o       = ready_q;
  assign a15_o         = a15_q;
  assign cpu_data_in_o = rdata_q;
endmodule

// File: tb/tb_bus_mux_sequencer.sv
// tb_bus_mux_sequencer: random and directed accesses checked against a tick-counting access model
module tb_bus_mux_sequencer;
  localparam int W = 4;
`ifdef MUX_TURBO_EN
  localparam int P = 1;
`else
  localparam int P = W;
`endif
  logic clk = 0, reset_n = 1, clk_en = 0, memen = 0, dbin = 0, we = 0;
  logic [14:0] a = 0;
  logic [15:0] wd = 0;
  logic [7:0] xd = 0;
  logic ready, a15, ext_we, busy;
  logic [7:0] ext_do;
  logic [15:0] cpu_di;
  int checks = 0, errors = 0;
  bit act = 0, dn = 0;
  int k = 0;
  logic [15:0] rd = 0;
  bus_mux_sequencer #(.WAIT_CYCLES(W)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clk_en_i(clk_en), .memen_i(memen), .dbin_i(dbin), .we_i(we),
    .a_i(a), .cpu_data_out_i(wd), .ext_data_in_i(xd), .ready_o(ready), .a15_o(a15),
    .ext_data_out_o(ext_do), .ext_we_o(ext_we), .cpu_data_in_o(cpu_di), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit wide_f(input logic [14:0] x);
    return (x[14:12] == 3'd0) || (x[14:12] == 3'd4 && x[11:9] == 3'd0);
  endfunction
  task automatic compare_all();
    check("ready", 16'(ready), 16'(!act));
    check("a15", 16'(a15), 16'(act && k < P));
    check("busy", 16'(busy), 16'(act));
    check("ext_we", 16'(ext_we), 16'(act && memen && !dbin && we));
    check("ext_data_out", 16'(ext_do), 16'(act ? (k < P ? wd[7:0] : wd[15:8]) : 8'h00));
    check("cpu_data_in", cpu_di, rd);
  endtask
  task automatic model_tick();
    if (act) begin
      if (!memen) act = 0;
      else begin
        if (k == P - 1 && dbin) rd[7:0] = xd;
        if (k == 2 * P - 1) begin
          if (dbin) rd[15:8] = xd;
          act = 0;
          dn = 1;
        end
        k++;
      end
    end else if (dn) begin
      if (!memen) dn = 0;
    end else if (memen && !wide_f(a)) begin
      act = 1;
      k = 0;
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (clk_en) model_tick();
    #1;
    compare_all();
    @(negedge clk);
  endtask
  task automatic idle_out();
    memen = 0;
    clk_en = 1;
    cyc();
    cyc();
  endtask
  initial begin
    int lowcnt, wcnt;
    #2 reset_n = 0;
    #1;
    compare_all();
    check("reset_ready", 16'(ready), 16'd1);
    @(negedge clk);
    reset_n = 1;
    // T1 wide access: no wait states
    memen = 1; dbin = 1; a = 15'h0100; clk_en = 1;
    repeat (4) cyc();
    check("t1_ready", 16'(ready), 16'd1);
    idle_out();
    // T2 read from >9800
    memen = 1; dbin = 1; we = 0; a = 15'h4C00;
    lowcnt = 0;
    for (int i = 0; i < 2 * P + 3; i++) begin
      xd = a15 ? 8'h5A : 8'hA5;
      cyc();
      if (!ready) lowcnt++;
    end
    check("t2_low_ticks", 16'(lowcnt), 16'(2 * P));
    check("t2_word", cpu_di, 16'hA55A);
    idle_out();
    // T3 write to >8C00
    memen = 1; dbin = 0; we = 1; a = 15'h4600; wd = 16'h1234;
    lowcnt = 0; wcnt = 0;
    for (int i = 0; i < 2 * P + 3; i++) begin
      cyc();
      if (!ready) lowcnt++;
      if (ext_we && ext_do == 8'h34) wcnt++;
    end
    check("t3_low_ticks", 16'(lowcnt), 16'(2 * P));
    check("t3_odd_writes", 16'(wcnt), 16'(P));
    idle_out();
    // T4 abort read at >6000 after 5 ticks
    memen = 1; dbin = 1; we = 0; a = 15'h3000;
    for (int i = 0; i < 5; i++) begin
      xd = 8'(8'h30 + i);
      cyc();
    end
    memen = 0;
    cyc();
    check("t4_ready", 16'(ready), 16'd1);
    idle_out();
    // T5 async reset during EVEN
    memen = 1; dbin = 0; we = 1; a = 15'h4C00; wd = 16'hBEEF;
    repeat (P + 2) cyc();
    check("t5_in_even", 16'({busy, a15}), 16'b10);
    #2 reset_n = 0;
    act = 0; dn = 0; rd = 0;
    #1;
    compare_all();
    check("t5_reset_we", 16'(ext_we), 16'd0);
    @(negedge clk);
    reset_n = 1;
    idle_out();
    // random accesses with random clk_en gaps, aborts and address wiggle while busy
    repeat (80) begin
      int len;
      case ($urandom % 4)
        0: a = {3'b000, 12'($urandom)};
        1: a = {6'b100000, 9'($urandom)};
        default: a = 15'($urandom);
      endcase
      dbin = 1'($urandom);
      we = dbin ? 1'($urandom) : ($urandom % 4 != 0);
      wd = 16'($urandom);
      len = $urandom_range(1, 3 * P + 4);
      for (int i = 0; i < len; i++) begin
        memen = 1;
        clk_en = ($urandom % 4 != 0);
        xd = 8'($urandom);
        if (act && $urandom % 5 == 0) a = 15'($urandom);
        cyc();
      end
      for (int i = 0; i < $urandom_range(1, 3); i++) begin
        memen = 0;
        clk_en = 1'($urandom);
        cyc();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
